// File: rtl/fb_pkg.sv
// Shared types and sizing for the frame-buffer access arbiter.
// Pixel address/data widths derive from the matrix geometry.
package fb_pkg;

    localparam int unsigned MATRIX_SIZE = 8;
    localparam int unsigned COLOR_DEPTH = 8;
    localparam int unsigned ADDR_W      = $clog2(MATRIX_SIZE * MATRIX_SIZE);
    localparam int unsigned DATA_W      = COLOR_DEPTH;

    typedef enum logic [1:0] {
        StRun,
        StSwapWait,
        StCopyRd,
        StCopyWr
    } fb_state_e;

    typedef enum logic [2:0] {
        GntNone,
        GntScan,
        GntCopy,
        GntWa,
        GntWb
    } fb_grant_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a global enable.
// On a tie the requester that did not win last time is granted.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    // 1 = B was granted most recently; reset to B so A wins the first tie
    logic last_b_q;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (en) begin
            if (req_a && req_b) begin
                gnt_a = last_b_q;
                gnt_b = ~last_b_q;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b_q <= 1'b1;
        end else if (gnt_a) begin
            last_b_q <= 1'b0;
        end else if (gnt_b) begin
            last_b_q <= 1'b1;
        end
    end

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port frame-buffer RAM arbiter: scan reads first, then the post-swap
// front-to-back copy, then two round-robin pixel writers on the back bank.
module fb_access_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W  = fb_pkg::ADDR_W,
    parameter int unsigned DATA_W  = fb_pkg::DATA_W,
    parameter bit          COPY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_end,
    input  logic              scan_en,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_valid,
    input  logic              wa_valid,
    output logic              wa_ready,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              swap_req,
    output logic              swap_busy,
    output logic              swap_done,
    output logic              front_bank,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W:0]   ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [ADDR_W-1:0] LastIdx = '1;

    fb_state_e         state_q, state_d;
    fb_grant_e         grant;
    logic              front_q, front_d;
    logic [ADDR_W-1:0] copy_idx_q, copy_idx_d;
    logic [DATA_W-1:0] copy_buf_q;
    logic              copy_pend_q, copy_pend_d;
    logic              scan_valid_q;
    logic [DATA_W-1:0] scan_data_q;
    logic              swap_done_q, swap_done_d;
    logic [DATA_W-1:0] copy_wdata;
    logic              arb_en;
    logic              gnt_a;
    logic              gnt_b;

    assign arb_en = ~rst & ~scan_en & (state_q == StRun);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .en    (arb_en),
        .req_a (wa_valid),
        .req_b (wb_valid),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    // The read issued in COPY_RD returns in the very next cycle, which is also
    // the first COPY_WR opportunity, so forward it instead of waiting for copy_buf.
    assign copy_wdata = copy_pend_q ? ram_rdata : copy_buf_q;

    always_comb begin
        grant       = GntNone;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        state_d     = state_q;
        front_d     = front_q;
        copy_idx_d  = copy_idx_q;
        swap_done_d = 1'b0;

        if (!rst) begin
            if (scan_en) begin
                grant    = GntScan;
                ram_en   = 1'b1;
                ram_addr = {front_q, scan_addr};
            end else if (state_q == StCopyRd) begin
                grant    = GntCopy;
                ram_en   = 1'b1;
                ram_addr = {front_q, copy_idx_q};
            end else if (state_q == StCopyWr) begin
                grant     = GntCopy;
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = {~front_q, copy_idx_q};
                ram_wdata = copy_wdata;
            end else if (gnt_a) begin
                grant     = GntWa;
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = {~front_q, wa_addr};
                ram_wdata = wa_data;
            end else if (gnt_b) begin
                grant     = GntWb;
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = {~front_q, wb_addr};
                ram_wdata = wb_data;
            end
        end

        unique case (state_q)
            StRun: begin
                if (swap_req) begin
                    state_d = StSwapWait;
                end
            end
            StSwapWait: begin
                if (frame_end) begin
                    front_d    = ~front_q;
                    copy_idx_d = '0;
                    if (COPY_EN) begin
                        state_d = StCopyRd;
                    end else begin
                        state_d     = StRun;
                        swap_done_d = 1'b1;
                    end
                end
            end
            StCopyRd: begin
                if (grant == GntCopy) begin
                    state_d = StCopyWr;
                end
            end
            StCopyWr: begin
                if (grant == GntCopy) begin
                    if (copy_idx_q == LastIdx) begin
                        state_d     = StRun;
                        swap_done_d = 1'b1;
                        copy_idx_d  = '0;
                    end else begin
                        state_d    = StCopyRd;
                        copy_idx_d = copy_idx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    assign copy_pend_d = (grant == GntCopy) && (state_q == StCopyRd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRun;
            front_q      <= 1'b0;
            copy_idx_q   <= '0;
            copy_buf_q   <= '0;
            copy_pend_q  <= 1'b0;
            scan_valid_q <= 1'b0;
            scan_data_q  <= '0;
            swap_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            front_q      <= front_d;
            copy_idx_q   <= copy_idx_d;
            copy_pend_q  <= copy_pend_d;
            scan_valid_q <= scan_en;
            swap_done_q  <= swap_done_d;
            // Captured even when scan pre-empts the following COPY_WR slot
            if (copy_pend_q) begin
                copy_buf_q <= ram_rdata;
            end
            if (scan_valid_q) begin
                scan_data_q <= ram_rdata;
            end
        end
    end

    assign scan_valid = scan_valid_q;
    assign scan_data  = scan_valid_q ? ram_rdata : scan_data_q;
    assign swap_busy  = (state_q != StRun);
    assign swap_done  = swap_done_q;
    assign front_bank = front_q;
    assign wa_ready   = (grant == GntWa);
    assign wb_ready   = (grant == GntWb);

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter: vector table for grants and scan reads,
// plus hand sequences for swap, background copy and reset mid-copy.
module tb_fb_access_arbiter;

    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_end, scan_en, scan_valid;
    logic [AW-1:0] scan_addr;
    logic [DW-1:0] scan_data;
    logic          wa_valid, wa_ready, wb_valid, wb_ready;
    logic [AW-1:0] wa_addr, wb_addr;
    logic [DW-1:0] wa_data, wb_data;
    logic          swap_req, swap_busy, swap_done, front_bank;
    logic          ram_en, ram_we;
    logic [AW:0]   ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    int tests = 0;
    int fails = 0;

    fb_access_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .COPY_EN (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_end  (frame_end),
        .scan_en    (scan_en),
        .scan_addr  (scan_addr),
        .scan_data  (scan_data),
        .scan_valid (scan_valid),
        .wa_valid   (wa_valid),
        .wa_ready   (wa_ready),
        .wa_addr    (wa_addr),
        .wa_data    (wa_data),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .swap_req   (swap_req),
        .swap_busy  (swap_busy),
        .swap_done  (swap_done),
        .front_bank (front_bank),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM model, 1-cycle read latency; fill loads a known pattern
    logic [DW-1:0] mem [0:127];
    logic          fill = 1'b0;
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       s_en;
        logic       a_v;
        logic       b_v;
        logic [5:0] s_addr;
        logic       e_en;
        logic       e_we;
        logic [6:0] e_addr;
        logic [7:0] e_wdata;
        logic       e_ra;
        logic       e_rb;
        logic       e_sv;
        logic [7:0] e_sd;
    } vec_t;

    vec_t vecs [10];

    int sv_err, sd_err, blk_err, done_cnt, mism;
    logic prev_scan, found, got_done;

    initial begin
        // wa writes 0xA1 to pixel 1, wb writes 0xB2 to pixel 2, back bank = 1
        vecs[0] = '{1'b0, 1'b1, 1'b1, 6'd0, 1'b1, 1'b1, 7'h41, 8'hA1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 6'd0, 1'b1, 1'b1, 7'h42, 8'hB2, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 6'd0, 1'b1, 1'b1, 7'h41, 8'hA1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 6'd0, 1'b1, 1'b1, 7'h42, 8'hB2, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 6'd5, 1'b1, 1'b0, 7'h05, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 6'd0, 1'b1, 1'b1, 7'h41, 8'hA1, 1'b1, 1'b0, 1'b1, 8'h5F};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 6'd0, 1'b1, 1'b1, 7'h42, 8'hB2, 1'b0, 1'b1, 1'b0, 8'h5F};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 7'h41, 8'hA1, 1'b1, 1'b0, 1'b0, 8'h5F};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5F};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 6'd0, 1'b1, 1'b1, 7'h42, 8'hB2, 1'b0, 1'b1, 1'b0, 8'h5F};

        // Reset with requests pending: nothing may be granted
        rst = 1'b1; fill = 1'b1;
        frame_end = 1'b0; swap_req = 1'b0;
        scan_en = 1'b1; scan_addr = '0;
        wa_valid = 1'b1; wa_addr = 6'd1; wa_data = 8'hA1;
        wb_valid = 1'b1; wb_addr = 6'd2; wb_data = 8'hB2;
        repeat (3) tick();
        #3;
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_wa_ready", wa_ready, 0);
        chk("rst_wb_ready", wb_ready, 0);
        chk("rst_scan_valid", scan_valid, 0);
        chk("rst_scan_data", scan_data, 0);
        chk("rst_swap_busy", swap_busy, 0);
        chk("rst_swap_done", swap_done, 0);
        chk("rst_front_bank", front_bank, 0);
        tick();
        rst = 1'b0; fill = 1'b0; scan_en = 1'b0; wa_valid = 1'b0; wb_valid = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            scan_en = vecs[i].s_en; scan_addr = vecs[i].s_addr;
            wa_valid = vecs[i].a_v; wb_valid = vecs[i].b_v;
            #3;
            chk($sformatf("v%0d_ram_en", i), ram_en, vecs[i].e_en);
            chk($sformatf("v%0d_ram_we", i), ram_we, vecs[i].e_we);
            if (vecs[i].e_en) chk($sformatf("v%0d_ram_addr", i), ram_addr, vecs[i].e_addr);
            if (vecs[i].e_we) chk($sformatf("v%0d_ram_wdata", i), ram_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_wa_ready", i), wa_ready, vecs[i].e_ra);
            chk($sformatf("v%0d_wb_ready", i), wb_ready, vecs[i].e_rb);
            chk($sformatf("v%0d_scan_valid", i), scan_valid, vecs[i].e_sv);
            chk($sformatf("v%0d_scan_data", i), scan_data, vecs[i].e_sd);
        end

        // Write 0xE0 to pixel 3 of the back bank
        tick();
        wa_valid = 1'b1; wb_valid = 1'b0; wa_addr = 6'd3; wa_data = 8'hE0;
        #3;
        chk("wr3_ready", wa_ready, 1);
        chk("wr3_addr", ram_addr, 7'h43);
        // frame_end in RUN is ignored
        tick();
        wa_valid = 1'b0; frame_end = 1'b1;
        tick();
        frame_end = 1'b0; swap_req = 1'b1;
        #3;
        chk("fe_in_run_ignored", front_bank, 0);
        tick();
        swap_req = 1'b0; wa_valid = 1'b1;
        #3;
        chk("swap_busy_accept", swap_busy, 1);
        chk("swap_wait_blocks_wa", wa_ready, 0);
        repeat (9) tick();
        frame_end = 1'b1;
        #3;
        chk("swap_wait_front", front_bank, 0);
        tick();
        frame_end = 1'b0;
        #3;
        chk("swap_front_toggled", front_bank, 1);
        chk("copy_busy", swap_busy, 1);

        // Copy with scan stealing every other cycle
        sv_err = 0; sd_err = 0; blk_err = 0; done_cnt = 0; prev_scan = 1'b0;
        scan_addr = 6'd3;
        for (int i = 0; i < 400; i++) begin
            tick();
            scan_en = i[0];
            #3;
            if (scan_valid !== prev_scan) sv_err++;
            if (scan_valid && scan_data !== 8'hE0) sd_err++;
            if (swap_busy && (wa_ready || wb_ready)) blk_err++;
            if (swap_done) done_cnt++;
            prev_scan = scan_en;
        end
        chk("copy_scan_valid_timing", sv_err, 0);
        chk("copy_scan_data", sd_err, 0);
        chk("copy_writers_blocked", blk_err, 0);
        chk("copy_done_pulses", done_cnt, 1);
        chk("copy_busy_cleared", swap_busy, 0);
        mism = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== mem[64 + i]) mism++;
        chk("copy_bank_match", mism, 0);
        chk("copy_front_px3", mem[67], 8'hE0);
        chk("copy_front_px1", mem[65], 8'hA1);

        // Reset in the middle of the next copy, at pixel 20's write
        tick();
        scan_en = 1'b0; wa_valid = 1'b1; wa_addr = 6'd9; swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            #3;
            if (ram_en && ram_we && ram_addr == 7'h54) found = 1'b1;
        end
        chk("copy_wr20_seen", found, 1);
        rst = 1'b1;
        #1;
        chk("midrst_front", front_bank, 0);
        chk("midrst_busy", swap_busy, 0);
        chk("midrst_done", swap_done, 0);
        chk("midrst_ram_en", ram_en, 0);
        chk("midrst_ram_we", ram_we, 0);
        chk("midrst_ram_addr", ram_addr, 0);
        chk("midrst_wa_ready", wa_ready, 0);
        chk("midrst_scan_valid", scan_valid, 0);
        tick();
        rst = 1'b0; wa_valid = 1'b0;
        tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        #3;
        chk("postrst_swap_accept", swap_busy, 1);
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < 300 && !got_done; i++) begin
            tick();
            #3;
            if (swap_done) got_done = 1'b1;
        end
        chk("postrst_swap_done", got_done, 1);
        chk("postrst_front", front_bank, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
